// File: rtl/rtc_reg_bus_arbiter.sv
// rtc_reg_bus_arbiter
// Round-robin arbiter between the host wrapper (port 0) and the RTC core
// (port 1) for the RTC configuration-register bus. It runs one transaction
// at a time: IDLE -> BUSY (chip-select held) -> DONE (completion pulse).
// Every output is a flop, so the MC interface and both requesters see clean,
// glitch-free signals.

module rtc_reg_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_r_neg_w0,
    input  logic        i_r_neg_w1,
    input  logic [5:0]  i_addr0,
    input  logic [5:0]  i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic        o_err0,
    output logic        o_err1,
    output logic        o_cs,
    output logic        o_r_neg_w,
    output logic [5:0]  o_addr,
    output logic [31:0] o_bus_data,
    input  logic [31:0] i_reg_data,
    input  logic        i_ack,
    input  logic        i_error
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value seen in the final BUSY cycle before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  timer;
    logic        last_grant;
    logic        cur_port;

    logic        pick;
    logic        finish;
    logic [31:0] fin_rdata;
    logic        fin_err;

    // Choose the winner: a lone requester always wins, a tie goes to the port
    // that was not served last.
    always_comb begin
        pick = 1'b0;
        if (i_req0 && i_req1) begin
            pick = ~last_grant;
        end else if (i_req1) begin
            pick = 1'b1;
        end
    end

    // Work out how a BUSY cycle ends: an ack wins over the timeout, a write
    // returns zero data, and a timeout returns zero data with the error flag.
    always_comb begin
        finish    = i_ack || (timer == TIMEOUT_LAST);
        fin_rdata = 32'd0;
        fin_err   = 1'b1;
        if (i_ack) begin
            fin_rdata = o_r_neg_w ? i_reg_data : 32'd0;
            fin_err   = i_error;
        end
    end

    // Sequencer: the command register doubles as the bus outputs, so it stays
    // stable for the whole BUSY state; completion status lives only in DONE.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            timer      <= 8'd0;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            o_cs       <= 1'b0;
            o_r_neg_w  <= 1'b0;
            o_addr     <= 6'd0;
            o_bus_data <= 32'd0;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_rdata0   <= 32'd0;
            o_rdata1   <= 32'd0;
            o_err0     <= 1'b0;
            o_err1     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req0 || i_req1) begin
                        cur_port   <= pick;
                        o_r_neg_w  <= pick ? i_r_neg_w1 : i_r_neg_w0;
                        o_addr     <= pick ? i_addr1 : i_addr0;
                        o_bus_data <= pick ? i_wdata1 : i_wdata0;
                        timer      <= 8'd0;
                        o_cs       <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        o_cs  <= 1'b0;
                        state <= ST_DONE;
                        if (cur_port) begin
                            o_ack1   <= 1'b1;
                            o_rdata1 <= fin_rdata;
                            o_err1   <= fin_err;
                        end else begin
                            o_ack0   <= 1'b1;
                            o_rdata0 <= fin_rdata;
                            o_err0   <= fin_err;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_DONE: begin
                    o_ack0     <= 1'b0;
                    o_ack1     <= 1'b0;
                    o_rdata0   <= 32'd0;
                    o_rdata1   <= 32'd0;
                    o_err0     <= 1'b0;
                    o_err1     <= 1'b0;
                    last_grant <= cur_port;
                    timer      <= 8'd0;
                    state      <= ST_IDLE;
                end
                default: begin
                    o_cs  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_reg_bus_arbiter.sv
// tb_rtc_reg_bus_arbiter
// Directed bench for the RTC register-bus arbiter: a table of single
// transactions with hand-computed results, plus hand-written sequences for
// continuous ties, reset during BUSY and stray acks while idle.

module tb_rtc_reg_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic        i_sys_clk = 1'b0;
    logic        i_reset;
    logic        i_req0, i_req1;
    logic        i_r_neg_w0, i_r_neg_w1;
    logic [5:0]  i_addr0, i_addr1;
    logic [31:0] i_wdata0, i_wdata1;
    logic [31:0] o_rdata0, o_rdata1;
    logic        o_ack0, o_ack1;
    logic        o_err0, o_err1;
    logic        o_cs;
    logic        o_r_neg_w;
    logic [5:0]  o_addr;
    logic [31:0] o_bus_data;
    logic [31:0] i_reg_data;
    logic        i_ack;
    logic        i_error;

    int checks = 0;
    int errors = 0;

    // 100 MHz system clock.
    always #5 i_sys_clk = ~i_sys_clk;

    rtc_reg_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_sys_clk  (i_sys_clk),
        .i_reset    (i_reset),
        .i_req0     (i_req0),
        .i_req1     (i_req1),
        .i_r_neg_w0 (i_r_neg_w0),
        .i_r_neg_w1 (i_r_neg_w1),
        .i_addr0    (i_addr0),
        .i_addr1    (i_addr1),
        .i_wdata0   (i_wdata0),
        .i_wdata1   (i_wdata1),
        .o_rdata0   (o_rdata0),
        .o_rdata1   (o_rdata1),
        .o_ack0     (o_ack0),
        .o_ack1     (o_ack1),
        .o_err0     (o_err0),
        .o_err1     (o_err1),
        .o_cs       (o_cs),
        .o_r_neg_w  (o_r_neg_w),
        .o_addr     (o_addr),
        .o_bus_data (o_bus_data),
        .i_reg_data (i_reg_data),
        .i_ack      (i_ack),
        .i_error    (i_error)
    );

    typedef struct {
        logic        req0;
        logic        req1;
        logic        rnw0;
        logic        rnw1;
        logic [5:0]  addr0;
        logic [5:0]  addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        int          ack_at;
        logic [31:0] reg_data;
        logic        reg_err;
        int          exp_port;
        int          exp_cs;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];
    vec_t post_reset_vec;

    int          obs_port;
    int          obs_cs;
    int          cmd_bad;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_other;
    logic        obs_cs_at_ack;
    logic        obs_after;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        i_req0 = 1'b0;     i_req1 = 1'b0;
        i_r_neg_w0 = 1'b0; i_r_neg_w1 = 1'b0;
        i_addr0 = 6'd0;    i_addr1 = 6'd0;
        i_wdata0 = 32'd0;  i_wdata1 = 32'd0;
        i_reg_data = 32'd0;
        i_ack = 1'b0;      i_error = 1'b0;
    endtask

    task automatic doReset();
        i_reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge i_sys_clk);
        i_reset = 1'b0;
    endtask

    // Drives one transaction from a negedge in IDLE, plays the register bank
    // and records what the arbiter did.
    task automatic applyStimulus(input vec_t v);
        logic        done;
        logic        exp_rnw;
        logic [5:0]  exp_addr;
        logic [31:0] exp_wdata;
        i_req0 = v.req0;      i_req1 = v.req1;
        i_r_neg_w0 = v.rnw0;  i_r_neg_w1 = v.rnw1;
        i_addr0 = v.addr0;    i_addr1 = v.addr1;
        i_wdata0 = v.wdata0;  i_wdata1 = v.wdata1;
        i_ack = 1'b0; i_error = 1'b0; i_reg_data = 32'd0;
        exp_rnw   = (v.exp_port == 1) ? v.rnw1   : v.rnw0;
        exp_addr  = (v.exp_port == 1) ? v.addr1  : v.addr0;
        exp_wdata = (v.exp_port == 1) ? v.wdata1 : v.wdata0;
        obs_port = -1; obs_cs = 0; cmd_bad = 0;
        obs_rdata = 32'd0; obs_err = 1'b0; obs_other = 1'b0; obs_cs_at_ack = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge i_sys_clk);
            i_ack = 1'b0; i_error = 1'b0; i_reg_data = 32'd0;
            if (o_ack0 || o_ack1) begin
                done = 1'b1;
                obs_port = (o_ack0 && o_ack1) ? 2 : (o_ack1 ? 1 : 0);
                obs_rdata = o_ack1 ? o_rdata1 : o_rdata0;
                obs_err = o_ack1 ? o_err1 : o_err0;
                obs_other = o_ack1 ? (o_ack0 || o_rdata0 != 0 || o_err0)
                                   : (o_ack1 || o_rdata1 != 0 || o_err1);
                obs_cs_at_ack = o_cs;
                i_req0 = 1'b0; i_req1 = 1'b0;
            end else if (o_cs) begin
                obs_cs++;
                if (o_r_neg_w !== exp_rnw || o_addr !== exp_addr || o_bus_data !== exp_wdata)
                    cmd_bad++;
                if (v.ack_at == obs_cs) begin
                    i_ack = 1'b1; i_error = v.reg_err; i_reg_data = v.reg_data;
                end
            end
        end
        i_req0 = 1'b0; i_req1 = 1'b0;
        @(negedge i_sys_clk);
        obs_after = o_ack0 || o_ack1 || o_cs;
    endtask

    task automatic runVector(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput({tag, "_port"},  32'(obs_port), 32'(v.exp_port));
        checkOutput({tag, "_cs_cycles"}, 32'(obs_cs), 32'(v.exp_cs));
        checkOutput({tag, "_rdata"}, obs_rdata, v.exp_rdata);
        checkOutput({tag, "_err"},   32'(obs_err), 32'(v.exp_err));
        checkOutput({tag, "_other_port_quiet"}, 32'(obs_other), 32'd0);
        checkOutput({tag, "_cs_low_at_ack"}, 32'(obs_cs_at_ack), 32'd0);
        checkOutput({tag, "_cmd_stable"}, 32'(cmd_bad), 32'd0);
        checkOutput({tag, "_single_pulse"}, 32'(obs_after), 32'd0);
    endtask

    initial begin
        int          grants[4];
        logic [5:0]  bursts[4];
        int          ng;
        int          nb;
        int          low_run;
        int          min_gap;
        logic        prev_cs;
        logic        started;
        int          stray;
        logic        cs_seen;

        //       req0  req1  rnw0  rnw1  addr0  addr1  wdata0        wdata1        ack reg_data      err port cs rdata         err
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h05, 6'h00, 32'h0,        32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 2,  32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h1E, 32'h0,        32'h000000A5, 1, 32'h12345678, 1'b0, 1, 1,  32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'h0A, 6'h33, 32'h01010101, 32'h0000BEEF, 3, 32'hCAFEF00D, 1'b1, 0, 3,  32'hCAFEF00D, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h0C, 6'h33, 32'h22223333, 32'h44445555, 1, 32'h0BADC0DE, 1'b0, 1, 1,  32'h0BADC0DE, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'h00, 6'h3F, 32'h0,        32'h0,        4, 32'h11112222, 1'b0, 1, 4,  32'h11112222, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 6'h01, 32'hFFFFFFFF, 32'h0,        1, 32'h77777777, 1'b1, 0, 1,  32'h0,        1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h15, 6'h00, 32'h0,        32'h0,        0, 32'h0,        1'b0, 0, 16, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'h00, 6'h2C, 32'h0,        32'h0,        16, 32'h5A5A5A5A, 1'b1, 1, 16, 32'h5A5A5A5A, 1'b1};
        post_reset_vec = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h2A, 6'h00, 32'h0, 32'h0, 2, 32'h0F0F0F0F, 1'b0, 0, 2, 32'h0F0F0F0F, 1'b0};

        // Reset values.
        doReset();
        checkOutput("rst_cs",     32'(o_cs), 32'd0);
        checkOutput("rst_rnw",    32'(o_r_neg_w), 32'd0);
        checkOutput("rst_addr",   32'(o_addr), 32'd0);
        checkOutput("rst_bus",    o_bus_data, 32'd0);
        checkOutput("rst_ack0",   32'(o_ack0), 32'd0);
        checkOutput("rst_ack1",   32'(o_ack1), 32'd0);
        checkOutput("rst_rdata0", o_rdata0, 32'd0);
        checkOutput("rst_rdata1", o_rdata1, 32'd0);
        checkOutput("rst_err0",   32'(o_err0), 32'd0);
        checkOutput("rst_err1",   32'(o_err1), 32'd0);

        // Stray ack/error while idle must not be forwarded.
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            i_ack = 1'b1; i_error = 1'b1; i_reg_data = 32'hFFFF0000;
            @(negedge i_sys_clk);
            if (o_ack0 || o_ack1 || o_err0 || o_err1 || o_cs) stray++;
        end
        i_ack = 1'b0; i_error = 1'b0; i_reg_data = 32'd0;
        @(negedge i_sys_clk);
        if (o_ack0 || o_ack1 || o_err0 || o_err1 || o_cs) stray++;
        checkOutput("idle_ack_ignored", 32'(stray), 32'd0);

        // Directed transaction table.
        for (int i = 0; i < 8; i++) begin
            runVector($sformatf("v%0d", i), vecs[i]);
        end

        // Both requests held continuously after reset: grants alternate 0,1,0,1.
        doReset();
        i_req0 = 1'b1; i_req1 = 1'b1;
        i_r_neg_w0 = 1'b1; i_r_neg_w1 = 1'b1;
        i_addr0 = 6'h11; i_addr1 = 6'h22;
        ng = 0; nb = 0; low_run = 0; min_gap = 99; prev_cs = 1'b0; started = 1'b0;
        for (int cyc = 0; cyc < 200 && ng < 4; cyc++) begin
            @(negedge i_sys_clk);
            i_ack = 1'b0; i_reg_data = 32'd0;
            if (o_ack0 || o_ack1) begin
                grants[ng] = o_ack1 ? 1 : 0;
                ng++;
            end
            if (o_cs) begin
                if (!prev_cs) begin
                    if (started && low_run < min_gap) min_gap = low_run;
                    if (nb < 4) bursts[nb] = o_addr;
                    nb++;
                end
                i_ack = 1'b1; i_reg_data = 32'h00C0FFEE;
                low_run = 0;
                started = 1'b1;
            end else begin
                low_run++;
            end
            prev_cs = o_cs;
        end
        i_req0 = 1'b0; i_req1 = 1'b0; i_ack = 1'b0;
        checkOutput("tie_grant_count", 32'(ng), 32'd4);
        checkOutput("tie_burst_count", 32'(nb), 32'd4);
        if (ng == 4 && nb == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("tie_grant%0d", i), 32'(grants[i]), 32'(i % 2));
                checkOutput($sformatf("tie_addr%0d", i), 32'(bursts[i]), (i % 2 == 1) ? 32'h22 : 32'h11);
            end
        end
        checkOutput("tie_cs_gap_ge2", 32'(min_gap >= 2), 32'd1);
        @(negedge i_sys_clk);

        // Reset in the middle of BUSY: cs drops at once and no ack follows.
        i_req0 = 1'b1; i_r_neg_w0 = 1'b1; i_addr0 = 6'h07;
        cs_seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !cs_seen; cyc++) begin
            @(negedge i_sys_clk);
            cs_seen = o_cs;
        end
        checkOutput("rst_busy_cs_seen", 32'(cs_seen), 32'd1);
        #2 i_reset = 1'b1;
        #1 checkOutput("rst_busy_cs_async", 32'(o_cs), 32'd0);
        i_req0 = 1'b0;
        repeat (2) @(negedge i_sys_clk);
        i_reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_sys_clk);
            if (o_ack0 || o_ack1 || o_cs) stray++;
        end
        checkOutput("rst_busy_no_ack", 32'(stray), 32'd0);
        runVector("post_rst", post_reset_vec);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_reg_bus_arbiter.md
# rtc_reg_bus_arbiter

Two-requester arbiter and sequencer for the RTC configuration-register bus. It sits between two bus masters, the host wrapper (port 0) and the internal RTC core (port 1), and the microcontroller interface's wrapper-side port (cs / r_neg_w / addr / data / ack / error). Each transaction is granted round-robin and runs to completion. The arbiter holds chip-select until the register bank acknowledges or a timeout expires, then returns read data and status to the winning requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of BUSY cycles without i_ack before the transaction is aborted with error; legal range 2..255.

Ports:
- i_sys_clk  in  1  system clock, 100 MHz
- i_reset  in  1  asynchronous, active-high reset
- i_req0 / i_req1  in  1  transaction request from port 0 / port 1
- i_r_neg_w0 / i_r_neg_w1  in  1  1 = read, 0 = write
- i_addr0 / i_addr1  in  6  register address
- i_wdata0 / i_wdata1  in  32  write data
- o_rdata0 / o_rdata1  out  32  read data, valid while the matching o_ack is high
- o_ack0 / o_ack1  out  1  one-cycle completion pulse
- o_err0 / o_err1  out  1  error status, valid with o_ack
- o_cs  out  1  chip select to the MC interface
- o_r_neg_w  out  1  read/write to the MC interface
- o_addr  out  6  address to the MC interface
- o_bus_data  out  32  write data to the MC interface
- i_reg_data  in  32  read data from the MC interface
- i_ack  in  1  acknowledge from the MC interface
- i_error  in  1  error from the MC interface

## Operation
- State machine: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - If any req is high, select the winner, latch its r_neg_w, addr and wdata into the command register, and go to BUSY.
  - If both req are high, grant the port not granted last (last_grant register; reset value 1, so port 0 wins the first tie).
  - If only one req is high, that port wins regardless of last_grant.
- BUSY:
  - o_cs = 1, and o_r_neg_w / o_addr / o_bus_data are driven from the command register and held stable for the whole state.
  - The timeout counter starts at 0 on BUSY entry and increments each BUSY cycle.
  - If i_ack = 1: capture i_reg_data (reads only; writes return 0) and i_error, then go to DONE.
  - Else, if the counter = TIMEOUT_CYCLES-1: capture rdata = 0 and err = 1, then go to DONE.
  - i_ack takes priority over timeout in the same cycle.
- DONE:
  - o_cs = 0.
  - The granted port's o_ack = 1 for exactly this cycle, with o_rdata/o_err valid. The other port's outputs stay 0.
  - Update last_grant, then go to IDLE unconditionally.
  - The mandatory cs-low cycle lets the MC interface clear its read/write enables between transactions.
- Requester protocol:
  - Hold req and the command stable until o_ack.
  - A req still high in the cycle after o_ack is treated as a new transaction.
  - Command inputs from a requester are ignored while it is not being latched.
- i_ack or i_error arriving while in IDLE or DONE is ignored and never forwarded.
- o_rdata* and o_err* are 0 whenever the corresponding o_ack is 0.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, last_grant = 1. All outputs are 0: o_cs, o_r_neg_w, o_addr, o_bus_data, o_ack*, o_rdata*, o_err*.
- Reset mid-transaction: o_cs drops immediately. No ack is issued for the aborted transaction, and the requester must reissue it.
- Latency:
  - req sampled high at edge N → o_cs high from edge N+1.
  - i_ack sampled at edge M → o_ack high from edge M+1 for one cycle, with o_cs low in that same cycle.
  - Earliest next o_cs is at edge M+3 (DONE at M+1, IDLE at M+2).
- Timeout: if no i_ack, o_cs stays high for exactly TIMEOUT_CYCLES cycles, followed by an o_ack/o_err pulse.
- Throughput: at most one transaction per 3 + (ack latency) cycles. No pipelining and no outstanding transactions.

## Test plan
- Single read on port 0: addr = 6'h05, register returns 32'hDEADBEEF with i_ack 2 cycles after o_cs → o_cs high 2 cycles, then o_ack0 pulse with o_rdata0 = 32'hDEADBEEF, o_err0 = 0, o_ack1 = 0.
- Single write on port 1: addr = 6'h1E, wdata = 32'h0000_00A5 → o_bus_data = 32'hA5 and o_r_neg_w = 0 for all cs cycles; o_ack1 pulse with o_rdata1 = 0.
- Simultaneous req0 and req1 held continuously after reset → grant order 0, 1, 0, 1. Each o_cs burst is separated by at least 2 low cycles, and o_addr matches the granted port.
- No i_ack with TIMEOUT_CYCLES = 16 → o_cs high for exactly 16 cycles, then o_ack pulse with err = 1 and rdata = 0.
- i_ack together with i_error = 1 on the timeout cycle → err = 1 and rdata = i_reg_data; the completion is treated as acked, not timed out.
- Reset asserted during BUSY → o_cs = 0 asynchronously and no o_ack pulse. After release, a new port-0 request completes normally.
